// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline pause/bubble control for load-use, redirect flush and data-memory wait,
// with a memory-wait watchdog and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int FETCH_LAT   = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_is_load_i,
    input  logic             ex_redirect_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_pause_o,
    output logic             if_id_pause_o,
    output logic             if_id_bubble_o,
    output logic             id_ex_pause_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_pause_o,
    output logic             ex_mem_bubble_o,
    output logic             mem_wb_pause_o,
    output logic             mem_wb_bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             timeout_err_o
);
    localparam int FW = $clog2(FETCH_LAT + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT, ERR} state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] stall_q;
    logic             mem_wait, load_use;

    assign mem_wait = mem_req_i & ~mem_ready_i;
    assign load_use = ex_is_load_i && ex_rd_i != '0 &&
                      ((id_rs1_used_i && id_rs1_i == ex_rd_i) || (id_rs2_used_i && id_rs2_i == ex_rd_i));

    always_comb begin
        state_d         = state_q;
        flush_d         = flush_q;
        wait_d          = wait_q;
        pc_pause_o      = 1'b0;
        if_id_pause_o   = 1'b0;
        if_id_bubble_o  = 1'b0;
        id_ex_pause_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        ex_mem_pause_o  = 1'b0;
        mem_wb_pause_o  = 1'b0;
        mem_wb_bubble_o = 1'b0;
        if (state_q == ERR) begin
            pc_pause_o     = 1'b1;
            if_id_pause_o  = 1'b1;
            id_ex_pause_o  = 1'b1;
            ex_mem_pause_o = 1'b1;
            mem_wb_pause_o = 1'b1;
        end else if (mem_wait) begin
            pc_pause_o      = 1'b1;
            if_id_pause_o   = 1'b1;
            id_ex_pause_o   = 1'b1;
            ex_mem_pause_o  = 1'b1;
            mem_wb_bubble_o = 1'b1;
            wait_d          = (state_q == MEM_WAIT) ? wait_q + WW'(1) : WW'(1);
            state_d         = (state_q == MEM_WAIT && wait_q == WW'(MEM_TIMEOUT)) ? ERR : MEM_WAIT;
        end else begin
            wait_d = '0;
            if (ex_redirect_i) begin
                if_id_bubble_o = 1'b1;
                id_ex_bubble_o = 1'b1;
                flush_d        = FW'(FETCH_LAT - 1);
                state_d        = (FETCH_LAT > 1) ? FLUSH : RUN;
            end else begin
                if (load_use) begin
                    pc_pause_o     = 1'b1;
                    if_id_pause_o  = 1'b1;
                    id_ex_bubble_o = 1'b1;
                end
                // Leaving MEM_WAIT resumes a frozen flush without consuming a count this cycle.
                if (state_q == FLUSH) begin
                    if_id_bubble_o = 1'b1;
                    flush_d        = flush_q - FW'(1);
                    state_d        = (flush_q == FW'(1)) ? RUN : FLUSH;
                end else begin
                    state_d = (flush_q != '0) ? FLUSH : RUN;
                end
            end
        end
        if (!rst_ni) begin
            pc_pause_o      = 1'b0;
            if_id_pause_o   = 1'b0;
            id_ex_pause_o   = 1'b0;
            ex_mem_pause_o  = 1'b0;
            mem_wb_pause_o  = 1'b0;
            if_id_bubble_o  = 1'b1;
            id_ex_bubble_o  = 1'b1;
            mem_wb_bubble_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            flush_q <= '0;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            wait_q  <= wait_d;
            if (pc_pause_o && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign ex_mem_bubble_o = ~rst_ni;
    assign stall_cnt_o     = stall_q;
    assign timeout_err_o   = (state_q == ERR);
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus against a cycle-level reference model
// of the hazard rules, FETCH_LAT=3, MEM_TIMEOUT=8, CNT_W=4.
module tb_hazard_ctrl;
    localparam int FL = 3;
    localparam int MT = 8;
    localparam int CW = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          u1 = 1'b0, u2 = 1'b0, ld = 1'b0, redir = 1'b0, req = 1'b0, rdy = 1'b0;
    logic          pc_p, ifid_p, ifid_b, idex_p, idex_b, exmem_p, exmem_b, memwb_p, memwb_b, terr;
    logic [CW-1:0] scnt;
    logic [8:0]    ctl;

    int checks = 0, errors = 0;
    int m_flush = 0, m_waited = 0, m_stall = 0;
    bit m_err = 0;

    hazard_ctrl #(.FETCH_LAT(FL), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
        .ex_rd_i(ex_rd), .ex_is_load_i(ld), .ex_redirect_i(redir),
        .mem_req_i(req), .mem_ready_i(rdy),
        .pc_pause_o(pc_p), .if_id_pause_o(ifid_p), .if_id_bubble_o(ifid_b),
        .id_ex_pause_o(idex_p), .id_ex_bubble_o(idex_b),
        .ex_mem_pause_o(exmem_p), .ex_mem_bubble_o(exmem_b),
        .mem_wb_pause_o(memwb_p), .mem_wb_bubble_o(memwb_b),
        .stall_cnt_o(scnt), .timeout_err_o(terr)
    );

    // {pc, if_id p/b, id_ex p/b, ex_mem p/b, mem_wb p/b}
    assign ctl = {pc_p, ifid_p, ifid_b, idex_p, idex_b, exmem_p, exmem_b, memwb_p, memwb_b};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", 32'(ctl), 32'h055);
        chk("rst_cnt", 32'(scnt), 0);
        chk("rst_err", 32'(terr), 0);
        m_flush = 0; m_waited = 0; m_stall = 0; m_err = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare the control vector, then stall count and error flag after the edge.
    task automatic step(input string tag, input logic [4:0] r1, input logic [4:0] r2, input logic a1,
                        input logic a2, input logic [4:0] rd, input logic l, input logic rdr,
                        input logic rq, input logic ry);
        logic [8:0] e;
        bit lu, memw, resumed;
        id_rs1 = r1; id_rs2 = r2; u1 = a1; u2 = a2; ex_rd = rd; ld = l; redir = rdr; req = rq; rdy = ry;
        #1;
        lu   = l && rd != 0 && ((a1 && r1 == rd) || (a2 && r2 == rd));
        memw = rq && !ry;
        e    = '0;
        if (m_err) begin
            e = 9'b110101010;
        end else if (memw) begin
            e = 9'b110101001;
            if (m_waited == MT) m_err = 1;
            m_waited++;
        end else begin
            resumed  = m_waited > 0;
            m_waited = 0;
            if (rdr) begin
                e = 9'b001010000;
                m_flush = FL - 1;
            end else begin
                if (lu) e = 9'b110010000;
                if (m_flush > 0 && !resumed) begin
                    e[6] = 1'b1;
                    m_flush--;
                end
            end
        end
        chk({tag, "_ctl"}, 32'(ctl), 32'(e));
        if (e[8]) m_stall = (m_stall == 2**CW - 1) ? m_stall : m_stall + 1;
        @(posedge clk);
        #1;
        chk({tag, "_cnt"}, 32'(scnt), 32'(m_stall));
        chk({tag, "_err"}, 32'(terr), 32'(m_err));
    endtask

    initial begin
        do_reset();
        step("lu_rs1",    5, 0, 1, 0, 5, 1, 0, 0, 0);
        chk("lu_one", 32'(scnt), 1);
        step("lu_rd0",    0, 0, 1, 0, 0, 1, 0, 0, 0);
        step("lu_rs2",    0, 9, 0, 1, 9, 1, 0, 0, 0);
        step("lu_unused", 9, 9, 0, 0, 9, 1, 0, 0, 0);
        step("no_load",   5, 0, 1, 0, 5, 0, 0, 0, 0);
        step("redir",     0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("flush1",    0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("flush2",    0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("run",       0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("redir_a",   0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("fl_a1",     0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("redir_b",   0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("fl_b1",     0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("fl_b2",     0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("run_b",     0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("redir_lu",  5, 0, 1, 0, 5, 1, 1, 0, 0);
        step("fl_lu",     3, 0, 1, 0, 3, 1, 0, 0, 0);
        step("fl_c2",     0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("redir_m",   0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("fl_m1",     0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("fl_wait1",  0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("fl_wait2",  0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("fl_rdy",    0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("fl_resume", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("run_m",     0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        repeat (4) step("mw", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("mw_rel",    0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("mw_four", 32'(scnt), 4);
        do_reset();
        repeat (12) step("tmo", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("err_ign",   5, 0, 1, 0, 5, 1, 1, 0, 0);
        chk("err_sticky", 32'(terr), 1);
        do_reset();
        repeat (20) step("sat", 7, 0, 1, 0, 7, 1, 0, 0, 0);
        chk("sat_max", 32'(scnt), 15);
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (m_err && $urandom_range(3) == 0) do_reset();
            step("rnd", 5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 5'($urandom_range(3)), 1'($urandom_range(1)),
                 $urandom_range(5) == 0, $urandom_range(2) == 0, 1'($urandom_range(1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
